// File: rtl/booth_arbiter_pkg.sv
// booth_arbiter_pkg: shared state encoding and vote-code geometry for the booth arbiter.
package booth_arbiter_pkg;
    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 4;
    typedef enum logic [3:0] {
        IDLE, GRANT, SETUP, STROBE, RET_SETUP, RET_STROBE, DONE, CLOSE, FLUSH, CLOSED
    } state_t;
endpackage

// File: rtl/booth_arbiter_if.sv
// booth_arbiter_if: booth-side request/code/grant/done bundle.
interface booth_arbiter_if
    import booth_arbiter_pkg::*;
#(
    parameter int NUM_BOOTHS = 4,
    parameter int DIGITS     = booth_arbiter_pkg::DIGITS
);
    logic [NUM_BOOTHS-1:0]                req;
    logic [DIGIT_W*DIGITS*NUM_BOOTHS-1:0] code;
    logic [NUM_BOOTHS-1:0]                grant;
    logic [NUM_BOOTHS-1:0]                done;
    logic                                 done_status;
    modport master (output req, code, input grant, done, done_status);
    modport slave  (input req, code, output grant, done, done_status);
endinterface

// File: rtl/booth_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick from req starting at a registered pointer.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [IW-1:0] served,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_idx
);
    logic [IW-1:0] ptr_q, ptr_d;
    int j;
    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = (served == IW'(N - 1)) ? '0 : served + IW'(1);
        pick     = '0;
        pick_idx = '0;
        j        = 0;
        // Scan farthest offset first so the nearest requester at/after ptr wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_q) + k >= N) ? int'(ptr_q) + k - N : int'(ptr_q) + k;
            if (req[j]) begin
                pick     = N'(1) << j;
                pick_idx = IW'(j);
            end
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
endmodule

// File: rtl/booth_arbiter.sv
// booth_arbiter: round-robin sharing of one tally core between booths, replaying
// each latched code as digit/valid strobes and sequencing poll close.
module booth_arbiter
    import booth_arbiter_pkg::*;
#(
    parameter int NUM_BOOTHS = 4,
    parameter int DIGITS     = booth_arbiter_pkg::DIGITS
) (
    input  logic               clock,
    input  logic               reset_n,
    booth_arbiter_if.slave     bus,
    input  logic               poll_close,
    input  logic               poll_open,
    output logic               busy,
    output logic               closed,
    output logic [DIGIT_W-1:0] core_digit,
    output logic               core_valid,
    output logic               core_finish,
    input  logic               core_votestatus
);
    localparam int BW = $clog2(NUM_BOOTHS);
    localparam int IW = $clog2(DIGITS);
    localparam int CW = DIGIT_W * DIGITS;

    state_t                state_q, state_d;
    logic [BW-1:0]         w_q, w_d, pick_idx;
    logic [NUM_BOOTHS-1:0] pick, grant_q, grant_d, done_q, done_d;
    logic [CW-1:0]         code_q, code_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DIGIT_W-1:0]    digit_q, digit_d;
    logic                  status_q, status_d, done_status_q, done_status_d;
    logic                  busy_q, busy_d, closed_q, closed_d;
    logic                  valid_q, valid_d, finish_q, finish_d;
    logic                  take, serving;

    rr_arbiter #(.N(NUM_BOOTHS)) u_rr (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (bus.req),
        .advance  (state_q == DONE),
        .served   (w_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = poll_close ? CLOSE : (|pick ? GRANT : IDLE);
            GRANT:      state_d = SETUP;
            SETUP:      state_d = STROBE;
            STROBE:     state_d = (idx_q == IW'(DIGITS - 1)) ? RET_SETUP : SETUP;
            RET_SETUP:  state_d = RET_STROBE;
            RET_STROBE: state_d = DONE;
            DONE:       state_d = IDLE;
            CLOSE:      state_d = FLUSH;
            FLUSH:      state_d = CLOSED;
            CLOSED:     state_d = (poll_open && !poll_close) ? IDLE : CLOSED;
            default:    state_d = IDLE;
        endcase
        take    = (state_q == IDLE) && (state_d == GRANT);
        serving = state_d inside {GRANT, SETUP, STROBE, RET_SETUP, RET_STROBE};
        w_d     = take ? pick_idx : w_q;
        code_d  = take ? bus.code[CW*int'(pick_idx) +: CW] : code_q;
        idx_d   = (state_q == GRANT) ? '0 : (state_q == STROBE) ? idx_q + IW'(1) : idx_q;
        // Status is read after the last digit strobe, before the return strobe resets the core.
        status_d      = (state_q == RET_SETUP) ? core_votestatus : status_q;
        grant_d       = take ? pick : serving ? grant_q : '0;
        done_d        = (state_d == DONE) ? grant_q : '0;
        done_status_d = (state_d == DONE) && status_q;
        busy_d        = serving || (state_d == DONE);
        closed_d      = (state_d == CLOSED);
        digit_d       = (state_d == SETUP)  ? code_q[DIGIT_W*(DIGITS-1-int'(idx_d)) +: DIGIT_W] :
                        (state_d == STROBE) ? digit_q : '0;
        valid_d       = state_d inside {STROBE, RET_STROBE};
        finish_d      = (state_d == CLOSE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            w_q           <= '0;
            code_q        <= '0;
            idx_q         <= '0;
            status_q      <= 1'b0;
            grant_q       <= '0;
            done_q        <= '0;
            done_status_q <= 1'b0;
            busy_q        <= 1'b0;
            closed_q      <= 1'b0;
            digit_q       <= '0;
            valid_q       <= 1'b0;
            finish_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            w_q           <= w_d;
            code_q        <= code_d;
            idx_q         <= idx_d;
            status_q      <= status_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            done_status_q <= done_status_d;
            busy_q        <= busy_d;
            closed_q      <= closed_d;
            digit_q       <= digit_d;
            valid_q       <= valid_d;
            finish_q      <= finish_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.done_status = done_status_q;
    assign busy            = busy_q;
    assign closed          = closed_q;
    assign core_digit      = digit_q;
    assign core_valid      = valid_q;
    assign core_finish     = finish_q;
endmodule

// File: doc/booth_arbiter.md
# booth_arbiter

Shares one vote-tally core between NUM_BOOTHS voting booths. Each booth presents a 4-digit code with a request. The arbiter grants booths round-robin, latches the granted code, and replays it to the tally core as a digit/valid strobe sequence. It then returns the core to its idle state and reports the outcome to the booth. It also sequences poll closing by driving the core's finish input.

## Interface
Parameters:
- NUM_BOOTHS, 4, number of requesting booths (2..8)
- DIGITS, 4, digits per vote code (fixed by the tally core FSM)

Ports:
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_BOOTHS  level request per booth; held until matching done
- code  in  4*DIGITS*NUM_BOOTHS  booth i code in bits [16i+15:16i]; most significant digit first; sampled only at grant
- poll_close  in  1  level; request to close the poll and clear tallies
- poll_open  in  1  level; leave CLOSED state
- grant  out  NUM_BOOTHS  one-hot, booth currently served
- done  out  NUM_BOOTHS  one-cycle pulse to the served booth at end of service
- done_status  out  1  valid with done; 1 = counted candidate, 0 = null vote
- busy  out  1  high from GRANT through DONE
- closed  out  1  high in CLOSED state
- core_digit  out  4  digit to tally core
- core_valid  out  1  tally core valid strobe
- core_finish  out  1  tally core finish
- core_votestatus  in  1  tally core votestatus

## Operation
- All outputs are registered. Reset value of every output is 0. The round-robin pointer resets to 0.
- States and transitions:
  - IDLE:
    - if poll_close, go to CLOSE;
    - else if any req, go to GRANT with the winner.
  - GRANT:
    - set grant[w];
    - latch code[w] into code_q;
    - clear digit index;
    - go to SETUP.
  - SETUP:
    - drive core_digit from the current digit of code_q (MSD first);
    - core_valid=0, so the core computes its next state;
    - go to STROBE.
  - STROBE:
    - core_valid=1 and core_digit held;
    - increment the digit index;
    - if index == DIGITS, go to RET_SETUP, else go to SETUP.
  - RET_SETUP:
    - core_valid=0, core_digit=0;
    - sample core_votestatus into status_q;
    - go to RET_STROBE.
  - RET_STROBE:
    - core_valid=1; the core returns to its idle state;
    - go to DONE.
  - DONE:
    - done[w]=1, done_status=status_q;
    - grant cleared;
    - pointer = w+1 mod NUM_BOOTHS;
    - go to IDLE.
  - CLOSE:
    - core_finish=1 for one cycle;
    - go to FLUSH.
  - FLUSH:
    - core_finish=0 and core_valid=0 for one cycle, which lets the core apply its clear;
    - go to CLOSED.
  - CLOSED:
    - no grants issued;
    - closed=1;
    - when poll_open && !poll_close, go to IDLE.
- Arbitration:
  - the first set req at or above the pointer wins, searching upward with wrap;
  - this is evaluated only in IDLE.
- Boundary rules:
  - A req dropped mid-service is ignored; the service completes and done still pulses.
  - Changes to code after GRANT are ignored.
  - poll_close during service is deferred until DONE completes, then CLOSE is entered from IDLE. poll_close has priority over req in IDLE.
  - Only one grant bit and at most one done bit are ever high.
  - A booth cannot be re-granted in the cycle after its done; IDLE takes at least one cycle.
  - reset_n low at any point aborts the service with no done pulse and forces all outputs to 0 asynchronously.

## Timing
- Cycle numbering: req first seen in IDLE at cycle 0.
  - cycle 1: GRANT; grant visible
  - cycles 2..9: SETUP/STROBE pairs
  - cycles 10..11: RET_SETUP/RET_STROBE
  - cycle 12: done pulse
- Latency from req to done is 12 cycles. Throughput is one vote per 13 cycles.
- core_digit is stable for the SETUP and STROBE cycles of each digit. core_valid is never high two cycles in a row.
- Close sequence: CLOSE then FLUSH (2 cycles), then closed=1 in the third cycle.

## Structure
- Shared package holds:
  - the state enum (IDLE, GRANT, SETUP, STROBE, RET_SETUP, RET_STROBE, DONE, CLOSE, FLUSH, CLOSED);
  - the DIGITS=4 constant;
  - the digit width of 4.
- One sub-module, rr_arbiter:
  - combinational one-hot pick from req and pointer;
  - contains the registered pointer with an advance input.

## Test plan
- Booth 0, code 16'h3031 → core_digit sequence 3,0,3,1 with one core_valid pulse each, then one return strobe; with votestatus=1, done[0] pulses at cycle 12 with done_status=1.
- Booth 1, code 16'h9999 with votestatus=0 → done[1] pulses with done_status=0 and exactly 5 core_valid pulses.
- req=4'b0101 held continuously → grants in order 0, 2, 0, 2. Adding req[3] after the first done → order 0, 2, 3, 0.
- poll_close raised during booth 2's second digit → booth 2 completes with done. Next cycles show CLOSE (finish=1), then FLUSH, then closed=1. req is ignored until poll_open.
- reset_n pulsed low during STROBE of digit 3 → all outputs 0 immediately and no done pulse. After release a new req is granted, with pointer restarting at booth 0.
- Booth 0 drops req and changes code after GRANT → latched code still replayed and done[0] still pulses.
